// File: rtl/tone_sequencer.sv
// Stereo sample player: streams a ROM segment into the codec write FIFO,
// one-shot or looping, with per-channel arithmetic attenuation.
module tone_sequencer #(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 16,
    parameter int ROM_LAT = 1,
    parameter int ATT_W   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [ATT_W-1:0]  att_l,
    input  logic [ATT_W-1:0]  att_r,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    input  logic              write_ready,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              busy,
    output logic              done,
    output logic [7:0]        loop_count
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam int         LAT_W   = 2;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT - 1);

    logic [2:0]        state;
    logic              armed;
    logic              loop_q;
    logic [ADDR_W-1:0] base_q, len_q, ptr, idx;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DATA_W-1:0] sample, wd_l_q, wd_r_q, shift_l, shift_r;
    logic              last;

    assign shift_l  = $unsigned($signed(sample) >>> att_l);
    assign shift_r  = $unsigned($signed(sample) >>> att_r);
    assign last     = (idx == len_q - ADDR_W'(1));
    assign rom_addr = ptr;
    assign busy     = (state == S_FETCH) || (state == S_WAIT) || (state == S_WRITE);
    assign done     = (state == S_DONE);
    // The strobe is combinational so it can never fire in a cycle without ready.
    assign write           = reset_n && (state == S_WRITE) && write_ready;
    assign writedata_left  = write ? shift_l : wd_l_q;
    assign writedata_right = write ? shift_r : wd_r_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            loop_q     <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            ptr        <= '0;
            idx        <= '0;
            lat_cnt    <= '0;
            sample     <= '0;
            wd_l_q     <= '0;
            wd_r_q     <= '0;
            loop_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Start is latched on one edge and acted on at the next,
                    // so FETCH lands one cycle after the sampling edge.
                    if (armed) begin
                        armed <= 1'b0;
                        state <= (len_q == '0) ? S_DONE : S_FETCH;
                    end else if (start && !stop) begin
                        armed      <= 1'b1;
                        base_q     <= base_addr;
                        len_q      <= length;
                        loop_q     <= loop;
                        ptr        <= base_addr;
                        idx        <= '0;
                        loop_count <= '0;
                    end
                end
                S_FETCH: begin
                    lat_cnt <= '0;
                    state   <= stop ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    if (stop) begin
                        state <= S_DONE;
                    end else if (lat_cnt == LAT_LAST) begin
                        sample <= rom_q;
                        state  <= S_WRITE;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (write_ready) begin
                        wd_l_q <= shift_l;
                        wd_r_q <= shift_r;
                        if (!last) begin
                            idx <= idx + ADDR_W'(1);
                            ptr <= ptr + ADDR_W'(1);
                        end else if (loop_q) begin
                            idx <= '0;
                            ptr <= base_q;
                            if (loop_count != 8'hFF) loop_count <= loop_count + 8'd1;
                        end
                        state <= (stop || (last && !loop_q)) ? S_DONE : S_FETCH;
                    end else if (stop) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state  <= S_IDLE;
                        wd_l_q <= '0;
                        wd_r_q <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: stimulus pushes expected samples,
// a negedge monitor pops and compares on every write strobe.
module tb_tone_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, loop = 1'b0;
    logic [15:0] base_addr = '0, length = '0;
    logic [2:0]  att_l = '0, att_r = '0;
    logic [15:0] rom_addr;
    logic [23:0] rom_q = '0;
    logic        write_ready = 1'b1;
    logic        write;
    logic [23:0] writedata_left, writedata_right;
    logic        busy, done;
    logic [7:0]  loop_count;

    int checks = 0, errors = 0, cyc = 0, nwr = 0;
    bit busy_seen = 1'b0;
    bit prev_w = 1'b0;

    typedef struct { logic [23:0] l; logic [23:0] r; } exp_t;
    exp_t sb[$];
    int   wr_cyc[$];

    tone_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop(loop),
        .base_addr(base_addr), .length(length), .att_l(att_l), .att_r(att_r),
        .rom_addr(rom_addr), .rom_q(rom_q), .write_ready(write_ready),
        .write(write), .writedata_left(writedata_left),
        .writedata_right(writedata_right), .busy(busy), .done(done),
        .loop_count(loop_count)
    );

    always #10 clk = ~clk;

    function automatic logic [23:0] rom_fn(input logic [15:0] a);
        if (a == 16'h0100) return 24'h800000;
        if (a == 16'h0101) return 24'h400000;
        return {a[7:0] ^ 8'h5A, a};
    endfunction

    // One-cycle synchronous ROM (ROM_LAT = 1)
    always @(posedge clk) rom_q <= rom_fn(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
        if (busy) busy_seen = 1'b1;
        if (write) begin
            nwr++;
            wr_cyc.push_back(cyc);
            chk("write_needs_ready", {31'd0, write_ready}, 32'd1);
            chk("write_not_back_to_back", {31'd0, prev_w}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %h/%h, expected no write",
                         writedata_left, writedata_right);
            end else begin
                e = sb.pop_front();
                chk("left", {8'd0, writedata_left}, {8'd0, e.l});
                chk("right", {8'd0, writedata_right}, {8'd0, e.r});
            end
        end
        prev_w = write;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        exp_t e;
        e.l = l;
        e.r = r;
        sb.push_back(e);
    endtask

    task automatic push_seg(input logic [15:0] base, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 16'(i);
            push(rom_fn(a), rom_fn(a));
        end
    endtask

    task automatic wait_nwr(input int n, input int budget);
        int k = 0;
        while (nwr < n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_writes", {31'd0, nwr >= n}, 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        chk("wait_done", {31'd0, done}, 32'd1);
    endtask

    task automatic new_test();
        nwr = 0;
        wr_cyc.delete();
    endtask

    initial begin
        int c0;

        // Reset
        tick();
        tick();
        chk("rst_rom_addr", {16'd0, rom_addr}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_left", {8'd0, writedata_left}, 32'd0);
        chk("rst_right", {8'd0, writedata_right}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_loop_count", {24'd0, loop_count}, 32'd0);
        reset_n = 1'b1;

        // Zero-length segment goes straight to DONE
        new_test();
        start = 1'b1;
        length = 16'd0;
        tick();
        tick();
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_no_busy", {31'd0, busy_seen}, 32'd0);
        chk("len0_no_write", nwr, 32'd0);
        start = 1'b0;
        tick();
        chk("len0_back_idle", {31'd0, done}, 32'd0);

        // One-shot, 4 samples, write_ready held high
        new_test();
        base_addr = 16'h0010;
        length = 16'd4;
        push_seg(16'h0010, 4);
        c0 = cyc;
        start = 1'b1;
        wait_done(40);
        chk("oneshot_count", nwr, 32'd4);
        if (wr_cyc.size() == 4) begin
            chk("oneshot_first_latency", wr_cyc[0] - c0, 32'd5);
            for (int i = 0; i < 3; i++)
                chk("oneshot_spacing", wr_cyc[i+1] - wr_cyc[i], 32'd3);
        end
        chk("done_holds_left", {8'd0, writedata_left}, {8'd0, rom_fn(16'h0013)});
        start = 1'b0;
        tick();
        chk("oneshot_idle_done", {31'd0, done}, 32'd0);
        chk("oneshot_idle_zero", {8'd0, writedata_left}, 32'd0);

        // Backpressure on the 2nd sample
        new_test();
        base_addr = 16'h0020;
        length = 16'd3;
        push_seg(16'h0020, 3);
        start = 1'b1;
        wait_nwr(1, 20);
        write_ready = 1'b0;
        repeat (5) tick();
        chk("bp_no_write_while_low", nwr, 32'd1);
        c0 = cyc;
        write_ready = 1'b1;
        tick();
        chk("bp_write_on_return", nwr, 32'd2);
        if (wr_cyc.size() == 2) chk("bp_write_cycle", wr_cyc[1], c0 + 1);
        wait_done(20);
        chk("bp_count", nwr, 32'd3);
        start = 1'b0;
        tick();

        // Loop with address wrap, then stop
        new_test();
        base_addr = 16'hFFFE;
        length = 16'd3;
        loop = 1'b1;
        push_seg(16'hFFFE, 3);
        push_seg(16'hFFFE, 3);
        push_seg(16'hFFFE, 1);
        start = 1'b1;
        wait_nwr(3, 40);
        chk("loop_count_1", {24'd0, loop_count}, 32'd1);
        wait_nwr(6, 40);
        chk("loop_count_2", {24'd0, loop_count}, 32'd2);
        wait_nwr(7, 40);
        stop = 1'b1;
        tick();
        chk("stop_done", {31'd0, done}, 32'd1);
        stop = 1'b0;
        repeat (6) tick();
        chk("stop_no_more_writes", nwr, 32'd7);
        chk("stop_loop_count", {24'd0, loop_count}, 32'd2);
        start = 1'b0;
        loop = 1'b0;
        tick();

        // Attenuation
        new_test();
        base_addr = 16'h0100;
        length = 16'd2;
        att_l = 3'd1;
        att_r = 3'd0;
        push(24'hC00000, 24'h800000);
        push(24'h008000, 24'h400000);
        start = 1'b1;
        wait_nwr(1, 20);
        att_l = 3'd7;
        wait_done(20);
        start = 1'b0;
        att_l = 3'd0;
        tick();

        // Mid-play reset during WAIT, start held high
        new_test();
        base_addr = 16'h0030;
        length = 16'd4;
        start = 1'b1;
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_rom_addr", {16'd0, rom_addr}, 32'd0);
        chk("mrst_left", {8'd0, writedata_left}, 32'd0);
        tick();
        tick();
        chk("mrst_held_idle", {31'd0, busy}, 32'd0);
        chk("mrst_no_write", nwr, 32'd0);
        push_seg(16'h0030, 4);
        c0 = cyc;
        reset_n = 1'b1;
        wait_done(40);
        chk("mrst_replay_count", nwr, 32'd4);
        if (wr_cyc.size() > 0) chk("mrst_replay_latency", wr_cyc[0] - c0, 32'd5);
        start = 1'b0;
        tick();

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Parametrised stereo sample player for the audio-codec path. It streams a selectable segment of a sample ROM into the codec's write FIFO with a real write handshake, in one-shot or loop mode, with per-channel attenuation. It sits between the top-level control FSM (start/stop/done) and the codec's `write_ready`/`write`/`writedata_*` interface, and owns the ROM address bus.

## Interface

Parameters:
- `DATA_W`, 24: sample width; signed two's complement.
- `ADDR_W`, 16: ROM address width.
- `ROM_LAT`, 1: ROM read latency in cycles, from `rom_addr` to valid `rom_q`. Range 1..3.
- `ATT_W`, 3: attenuation shift width.

Ports:
- `clk`, in, 1: system clock, 50 MHz. All logic is on the rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: level request to play. Sampled in IDLE.
- `stop`, in, 1: abort request. Honoured in any active state.
- `loop`, in, 1: 1 selects loop mode, 0 selects one-shot. Latched at start.
- `base_addr`, in, ADDR_W: first ROM address of the segment. Latched at start.
- `length`, in, ADDR_W: number of samples in the segment. Latched at start.
- `att_l`, `att_r`, in, ATT_W: right arithmetic shift applied to the left/right sample. Sampled every write.
- `rom_addr`, out, ADDR_W: ROM address.
- `rom_q`, in, DATA_W: ROM data.
- `write_ready`, in, 1: codec FIFO has space.
- `write`, out, 1: one-cycle write strobe.
- `writedata_left`, `writedata_right`, out, DATA_W: stereo sample. Held between writes.
- `busy`, out, 1: high in FETCH, WAIT and WRITE.
- `done`, out, 1: high in DONE.
- `loop_count`, out, 8: completed passes in loop mode. Saturates at 255.

## Operation

- States: IDLE, FETCH, WAIT, WRITE, DONE.
- **IDLE**
  - If `start` is high, latch `base_addr`, `length` and `loop`, set the internal pointer to `base_addr`, clear the sample index and `loop_count`.
  - If the latched length is 0, go to DONE. Otherwise go to FETCH.
- **FETCH**: drive `rom_addr` = pointer, then go to WAIT. The ROM latency counter starts here.
- **WAIT**
  - Stay for ROM_LAT cycles counted from FETCH.
  - On the last cycle, capture `rom_q` into the sample register, then go to WRITE.
- **WRITE**
  - While `write_ready` is 0, hold the state with `write` low.
  - When `write_ready` is 1, in that cycle:
    - assert `write`;
    - drive `writedata_left` = sample >>> `att_l` and `writedata_right` = sample >>> `att_r` (sign-extending shift);
    - advance.
  - Advance when index < length−1: increment index and pointer, go to FETCH.
  - Advance at the end of the segment:
    - loop=1: pointer ← base, index ← 0, `loop_count` += 1 (saturating), go to FETCH.
    - loop=0: go to DONE.
- **DONE**: `done` is high. Stay while `start` is high. Go to IDLE when `start` is low. This is a four-phase handshake, so a held `start` does not retrigger.
- **stop**: when high in FETCH, WAIT or WRITE, go to DONE next cycle.
  - A write already strobing in that same cycle completes.
  - A pending sample is discarded.
- Pointer arithmetic is modulo 2^ADDR_W, so a segment may wrap past the top of the ROM.
- Simultaneous `stop` and `write_ready` in WRITE: the write is issued, then the state goes to DONE.
- Simultaneous `start` and `stop` in IDLE: `stop` wins and the state stays in IDLE.
- The outputs `writedata_*` are zeroed on entry to IDLE and hold their last written value in DONE.

## Timing

- Reset values: state IDLE, `rom_addr` 0, `write` 0, `writedata_*` 0, `busy` 0, `done` 0, `loop_count` 0, sample register 0.
- `reset_n` low mid-play returns the block to IDLE on the next edge with all reset values. No further writes are issued.
- `start` is sampled at edge t. FETCH is entered at t+1.
- First `write` comes at t+2+ROM_LAT at the earliest, when `write_ready` is held high.
- Steady-state throughput is one sample per 2+ROM_LAT cycles, plus any `write_ready` stall cycles.
- `write` is never high for two consecutive cycles.
- `write` is never high when `write_ready` was low in that cycle.
- `done` rises the cycle after the last write, or after the `stop` edge.
- `busy` and `done` are never high together.

## Test plan

- **Reset**
  - Stimulus: `reset_n`=0 for 2 cycles.
  - Required: every output at its reset value.
  - Then assert `start` with length 0. Required: `done`=1 one cycle later, no `write`, `busy` never high.
- **One-shot, ROM_LAT=1**
  - Stimulus: base 0x0010, length 4, `write_ready` tied 1.
  - Required: exactly 4 writes, 3 cycles apart, carrying ROM[0x10..0x13] on both channels.
  - Then `done`; dropping `start` returns the block to IDLE.
- **Backpressure**
  - Stimulus: `write_ready` low for 5 cycles during the 2nd sample.
  - Required: `write` stays low throughout, the sample is held, and it is written in the first cycle `write_ready` returns to 1.
  - Required: no sample lost or duplicated.
- **Loop and wrap**
  - Stimulus: loop=1, base 0xFFFE, length 3.
  - Required: address sequence FFFE, FFFF, 0000, FFFE, …
  - Required: `loop_count` increments on each pass.
  - Then assert `stop`. Required: DONE next cycle, no further writes.
- **Attenuation**
  - Stimulus: sample 0x800000, `att_l`=1, `att_r`=0.
  - Required: left=0xC00000, right=0x800000.
  - Stimulus: sample 0x400000, `att_l`=7. Required: left=0x008000.
- **Mid-play reset**
  - Stimulus: `reset_n` low during WAIT.
  - Required: IDLE next cycle, outputs zeroed, no `write`.
  - Stimulus: `start` held high throughout. Required: a new play is issued only after `reset_n` is released.
